lcd_scanout: RTL and testbench

LCD_SCANOUT -- requirements
Module: lcd_scanout

---
 rtl/gb_video_pkg.sv | 37 +++
 rtl/vga_timing.sv | 46 ++++
 rtl/lcd_scanout.sv | 175 +++++++++++++++++
 tb/tb_lcd_scanout.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/gb_video_pkg.sv
// Shared constants and types for the Game Boy to VGA scan-out path:
// 640x480@60 timing, Game Boy frame size, shade palette and border colour.
package gb_video_pkg;

   // VGA 640x480 timing, all counts in pixel clocks / lines
   localparam int H_VISIBLE    = 640;
   localparam int H_SYNC_START = 656;
   localparam int H_SYNC_END   = 752;
   localparam int H_TOTAL      = 800;

   localparam int V_VISIBLE    = 480;
   localparam int V_SYNC_START = 490;
   localparam int V_SYNC_END   = 492;
   localparam int V_TOTAL      = 525;

   // Game Boy LCD resolution
   localparam int GB_W = 160;
   localparam int GB_H = 144;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   // Shade 0 is the lightest, shade 3 the darkest (classic DMG greens)
   localparam rgb_t PALETTE [4] = '{
      '{8'hE0, 8'hF8, 8'hD0},
      '{8'h88, 8'hC0, 8'h70},
      '{8'h34, 8'h68, 8'h56},
      '{8'h08, 8'h18, 8'h20}
   };

   // Colour of the visible area surrounding the scaled game image
   localparam rgb_t BORDER_RGB = '{8'h40, 8'h40, 8'h40};

endpackage

// File: rtl/vga_timing.sv
// Free-running 800x525 raster counters with raw (undelayed) visible and
// active-low sync flags derived directly from the counter state.
module vga_timing
   import gb_video_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   output logic [9:0] o_hc,
   output logic [9:0] o_vc,
   output logic       o_h_last,
   output logic       o_v_last,
   output logic       o_visible,
   output logic       o_hsync_n,
   output logic       o_vsync_n
);

   logic [9:0] r_hc;
   logic [9:0] r_vc;
   logic       w_h_last;
   logic       w_v_last;

   assign w_h_last = (r_hc == 10'(H_TOTAL - 1));
   assign w_v_last = (r_vc == 10'(V_TOTAL - 1));

   // Raster counters: hc runs every clock, vc steps when hc wraps
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_hc <= '0;
         r_vc <= '0;
      end else if (w_h_last) begin
         r_hc <= '0;
         r_vc <= w_v_last ? 10'd0 : r_vc + 10'd1;
      end else begin
         r_hc <= r_hc + 10'd1;
      end
   end

   assign o_hc      = r_hc;
   assign o_vc      = r_vc;
   assign o_h_last  = w_h_last;
   assign o_v_last  = w_v_last;
   assign o_visible = (r_hc < 10'(H_VISIBLE)) && (r_vc < 10'(V_VISIBLE));
   assign o_hsync_n = !((r_hc >= 10'(H_SYNC_START)) && (r_hc < 10'(H_SYNC_END)));
   assign o_vsync_n = !((r_vc >= 10'(V_SYNC_START)) && (r_vc < 10'(V_SYNC_END)));

endmodule

// File: rtl/lcd_scanout.sv
// Scans a 160x144 Game Boy frame buffer out to 640x480 VGA, replicating each
// source pixel SCALE times in both directions inside a window placed at
// (H_OFFSET, V_OFFSET). The frame buffer is a synchronous RAM: the address
// issued in cycle N returns pix_in in cycle N+1, and the colour register
// captures it so every output lines up two cycles after the raster counters.
module lcd_scanout
   import gb_video_pkg::*;
#(
   parameter int H_OFFSET = 80,
   parameter int V_OFFSET = 24,
   parameter int SCALE    = 3
) (
   input  logic       rdclock,
   input  logic       reset,
   output logic [7:0] X_read,
   output logic [7:0] Y_read,
   input  logic [1:0] pix_in,
   output logic [7:0] red,
   output logic [7:0] green,
   output logic [7:0] blue,
   output logic       hsync,
   output logic       vsync,
   output logic       blank_n,
   output logic       frame_start
);

   // Window bounds are elaboration-time constants; no runtime arithmetic
   localparam int H_END = H_OFFSET + GB_W * SCALE;
   localparam int V_END = V_OFFSET + GB_H * SCALE;
   localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;

   logic [9:0]       w_hc;
   logic [9:0]       w_vc;
   logic             w_h_last;
   logic             w_v_last;
   logic             w_visible;
   logic             w_hsync_n;
   logic             w_vsync_n;
   logic             w_h_win;
   logic             w_v_win;
   logic             w_win;
   logic             w_h_win_last;

   logic [7:0]       r_x;
   logic [SUB_W-1:0] r_xsub;
   logic [7:0]       r_y;
   logic [SUB_W-1:0] r_ysub;

   logic             r_win_s1;
   logic             r_vis_s1;
   logic             r_hs_s1;
   logic             r_vs_s1;
   logic             r_vis_s2;
   logic             r_hs_s2;
   logic             r_vs_s2;
   rgb_t             r_rgb;
   rgb_t             w_rgb_next;

   vga_timing u_timing (
      .i_clk     (rdclock),
      .i_rst     (reset),
      .o_hc      (w_hc),
      .o_vc      (w_vc),
      .o_h_last  (w_h_last),
      .o_v_last  (w_v_last),
      .o_visible (w_visible),
      .o_hsync_n (w_hsync_n),
      .o_vsync_n (w_vsync_n)
   );

   assign w_h_win      = (w_hc >= 10'(H_OFFSET)) && (w_hc < 10'(H_END));
   assign w_v_win      = (w_vc >= 10'(V_OFFSET)) && (w_vc < 10'(V_END));
   assign w_win        = w_h_win && w_v_win;
   assign w_h_win_last = (w_hc == 10'(H_END - 1));

   // Column address: the register is updated from the current counter state
   // so that during each cycle it already names the pixel for that cycle.
   // It steps once per SCALE clocks inside the window and rests at 0 outside.
   always_ff @(posedge rdclock or posedge reset) begin
      if (reset) begin
         r_x    <= '0;
         r_xsub <= '0;
      end else if (w_win && !w_h_win_last) begin
         if (r_xsub == SUB_W'(SCALE - 1)) begin
            r_xsub <= '0;
            if (r_x != 8'(GB_W - 1)) begin
               r_x <= r_x + 8'd1;
            end
         end else begin
            r_xsub <= r_xsub + 1'b1;
         end
      end else begin
         r_x    <= '0;
         r_xsub <= '0;
      end
   end

   // Row address: evaluated at the end of each line; steps once per SCALE
   // window lines, holds after the window and returns to 0 as the frame wraps
   always_ff @(posedge rdclock or posedge reset) begin
      if (reset) begin
         r_y    <= '0;
         r_ysub <= '0;
      end else if (w_h_last) begin
         if (w_v_last) begin
            r_y    <= '0;
            r_ysub <= '0;
         end else if (w_v_win) begin
            if (r_ysub == SUB_W'(SCALE - 1)) begin
               r_ysub <= '0;
               if (r_y != 8'(GB_H - 1)) begin
                  r_y <= r_y + 8'd1;
               end
            end else begin
               r_ysub <= r_ysub + 1'b1;
            end
         end
      end
   end

   // First delay stage: timing flags now line up with pix_in from the RAM
   always_ff @(posedge rdclock or posedge reset) begin
      if (reset) begin
         r_win_s1 <= 1'b0;
         r_vis_s1 <= 1'b0;
         r_hs_s1  <= 1'b1;
         r_vs_s1  <= 1'b1;
      end else begin
         r_win_s1 <= w_win;
         r_vis_s1 <= w_visible;
         r_hs_s1  <= w_hsync_n;
         r_vs_s1  <= w_vsync_n;
      end
   end

   // Colour select: game pixel inside the window, border elsewhere on screen;
   // pix_in is only looked at while the delayed window flag is set
   always_comb begin
      w_rgb_next = '0;
      if (r_win_s1) begin
         w_rgb_next = PALETTE[pix_in];
      end else if (r_vis_s1) begin
         w_rgb_next = BORDER_RGB;
      end
   end

   // Second delay stage: registered colour plus the matching sync/blank flags
   always_ff @(posedge rdclock or posedge reset) begin
      if (reset) begin
         r_vis_s2 <= 1'b0;
         r_hs_s2  <= 1'b1;
         r_vs_s2  <= 1'b1;
         r_rgb    <= '0;
      end else begin
         r_vis_s2 <= r_vis_s1;
         r_hs_s2  <= r_hs_s1;
         r_vs_s2  <= r_vs_s1;
         r_rgb    <= w_rgb_next;
      end
   end

   assign X_read  = r_x;
   assign Y_read  = r_y;
   assign red     = r_rgb.r;
   assign green   = r_rgb.g;
   assign blue    = r_rgb.b;
   assign hsync   = r_hs_s2;
   assign vsync   = r_vs_s2;
   assign blank_n = r_vis_s2;

   // Frame marker follows the raw counters (not the pipeline) and is held
   // low while reset is asserted even though the counters sit at the origin
   assign frame_start = !reset && (w_hc == 10'd0) && (w_vc == 10'd0);

endmodule

// File: tb/tb_lcd_scanout.sv
module tb_lcd_scanout;

  localparam int W     = 44;
  localparam int H_OFF = 80;
  localparam int V_OFF = 24;
  localparam int SCALE = 3;
  localparam int GW    = 160;
  localparam int GH    = 144;

  localparam logic [23:0] PAL [4] = '{24'hE0F8D0, 24'h88C070, 24'h346856, 24'h081820};
  localparam logic [23:0] BORDER  = 24'h404040;
  // {frame_start, hsync, vsync, blank_n, rgb, X_read, Y_read} while in reset
  localparam logic [W-1:0] RESET_WORD = {4'b0110, 40'h0};

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] pix_in = 2'd0;
  logic [7:0] x_read, y_read, red, green, blue;
  logic       hsync, vsync, blank_n, frame_start;

  always #20 clk = ~clk;

  lcd_scanout #(.H_OFFSET(H_OFF), .V_OFFSET(V_OFF), .SCALE(SCALE)) dut (
    .rdclock     (clk),
    .reset       (reset),
    .X_read      (x_read),
    .Y_read      (y_read),
    .pix_in      (pix_in),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank_n     (blank_n),
    .frame_start (frame_start)
  );

  // ---------------- reference model ----------------
  logic [1:0] ram [GH][GW];

  function automatic bit in_win(input int h, input int v);
    return (h >= H_OFF) && (h < H_OFF + GW * SCALE) && (v >= V_OFF) && (v < V_OFF + GH * SCALE);
  endfunction

  // Expected outputs in the k-th cycle after reset release
  function automatic logic [W-1:0] model_word(input int k);
    int h, v, p, hd, vd;
    logic fs, hs, vs, bl;
    logic [23:0] rgb;
    logic [7:0] x, y;
    h  = k % 800;
    v  = (k / 800) % 525;
    fs = (h == 0) && (v == 0);
    x  = in_win(h, v) ? 8'((h - H_OFF) / SCALE) : 8'd0;
    y  = (v >= V_OFF && v < V_OFF + GH * SCALE) ? 8'((v - V_OFF) / SCALE) : 8'd0;
    if (k < 2) begin
      hs = 1'b1; vs = 1'b1; bl = 1'b0; rgb = 24'h0;
    end else begin
      p  = k - 2;
      hd = p % 800;
      vd = (p / 800) % 525;
      bl = (hd < 640) && (vd < 480);
      hs = !(hd >= 656 && hd < 752);
      vs = !(vd >= 490 && vd < 492);
      if (in_win(hd, vd)) rgb = PAL[ram[(vd - V_OFF) / SCALE][(hd - H_OFF) / SCALE]];
      else if (bl)        rgb = BORDER;
      else                rgb = 24'h0;
    end
    return {fs, hs, vs, bl, rgb, x, y};
  endfunction

  // Y_read is only pinned down before and inside the window lines
  function automatic logic [W-1:0] model_mask(input int k);
    int v;
    v = (k / 800) % 525;
    return (v >= V_OFF + GH * SCALE) ? {{(W-8){1'b1}}, 8'h00} : {W{1'b1}};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] msk_q[$];
  int n_vec = 0;
  int n_err = 0;
  int model_k = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expectation producer: one entry per clock cycle
  always @(posedge clk) begin
    #3;
    if (reset) begin
      model_k = 0;
      exp_q.push_back(RESET_WORD);
      msk_q.push_back({W{1'b1}});
    end else begin
      exp_q.push_back(model_word(model_k));
      msk_q.push_back(model_mask(model_k));
      model_k++;
    end
  end

  // Monitor: compare DUT outputs mid-cycle against the oldest expectation
  logic [W-1:0] mon_e, mon_m, mon_a;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_m = msk_q.pop_front();
      mon_a = {frame_start, hsync, vsync, blank_n, red, green, blue, x_read, y_read};
      check("cycle", 64'(mon_a & mon_m), 64'(mon_e & mon_m));
    end
  end

  // ---------------- frame buffer driver (1-cycle read latency) ----------------
  logic [7:0] ax, ay;
  bit         aw;
  always @(negedge clk) begin
    ax = x_read;
    ay = y_read;
    aw = !reset && in_win((model_k - 1) % 800, ((model_k - 1) / 800) % 525);
  end
  always @(posedge clk) begin
    #1;
    if (aw && ax < GW && ay < GH) pix_in = ram[ay][ax];
    else                          pix_in = 2'($urandom_range(0, 3));
  end

  // ---------------- directed checks ----------------
  task automatic goto(inout int cyc, input int k);
    while (cyc < k) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Starts right after reset release; cyc counts cycles since release
  task automatic run_segment(output int cyc_out);
    int cyc, cnt, blanks, lows;
    cyc = 0;
    @(negedge clk);
    check("frame_start_at_release", 64'(frame_start), 64'd1);
    while (hsync === 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("first_hsync_low_cycle", 64'(cyc), 64'd658);
    cnt = 0;
    while (hsync === 1'b0 && cnt < 200) begin
      @(negedge clk);
      cyc++;
      cnt++;
    end
    check("hsync_low_width", 64'(cnt), 64'd96);

    // Line 24: address sequence and origin pixel
    goto(cyc, 24 * 800 + 79);
    for (int h = 79; h <= 90; h++) begin
      check("x_read_line24", 64'(x_read), (h < H_OFF) ? 64'd0 : 64'((h - H_OFF) / SCALE));
      if (h - 2 == 79) check("border_col79", 64'({red, green, blue}), 64'(BORDER));
      if (h - 2 >= 80 && h - 2 <= 82) check("origin_pixel", 64'({red, green, blue}), 64'(PAL[3]));
      @(negedge clk);
      cyc++;
    end
    // Right edge of the window on line 24
    goto(cyc, 24 * 800 + 557);
    for (int h = 557; h <= 562; h++) begin
      check("x_read_right_edge", 64'(x_read), (h < 560) ? 64'd159 : 64'd0);
      if (h - 2 >= 557 && h - 2 <= 559) check("last_col_pixel", 64'({red, green, blue}), 64'(PAL[2]));
      if (h - 2 == 560) check("border_col560", 64'({red, green, blue}), 64'(BORDER));
      @(negedge clk);
      cyc++;
    end

    // Line 25 statistics (outputs for counter state of line 25)
    goto(cyc, 25 * 800 + 2);
    blanks = 0;
    lows   = 0;
    for (int i = 0; i < 800; i++) begin
      if (!blank_n && {red, green, blue} == 24'h0) blanks++;
      if (!hsync) lows++;
      if (i == 80) check("origin_pixel_line25", 64'({red, green, blue}), 64'(PAL[3]));
      @(negedge clk);
      cyc++;
    end
    check("line25_blank_count", 64'(blanks), 64'd160);
    check("line25_hsync_low_count", 64'(lows), 64'd96);

    goto(cyc, 26 * 800 + 83);
    check("origin_pixel_line26", 64'({red, green, blue}), 64'(PAL[3]));
    goto(cyc, 26 * 800 + 100);
    check("y_read_line26", 64'(y_read), 64'd0);
    goto(cyc, 27 * 800 + 82);
    check("pixel_row1_col0", 64'({red, green, blue}), 64'(PAL[ram[1][0]]));
    goto(cyc, 27 * 800 + 100);
    check("y_read_line27", 64'(y_read), 64'd1);
    goto(cyc, 30 * 800 + 100);
    check("y_read_line30", 64'(y_read), 64'd2);
    cyc_out = cyc;
  endtask

  initial begin
    int cyc;
    for (int y = 0; y < GH; y++)
      for (int x = 0; x < GW; x++)
        ram[y][x] = 2'($urandom_range(0, 3));
    ram[0][0]     = 2'd3;
    ram[0][1]     = 2'd1;
    ram[0][159]   = 2'd2;
    ram[143][159] = 2'd2;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    run_segment(cyc);

    // Reset in the middle of the frame, then time a fresh frame start
    goto(cyc, 33 * 800 + 345);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("midframe_reset_outputs",
          64'({frame_start, hsync, vsync, blank_n, red, green, blue, x_read, y_read}),
          64'(RESET_WORD));
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    run_segment(cyc);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
